// File: rtl/decomp_pkg.sv
// decomp_pkg: constants, mode encoding and lane result type shared by the
// Decompose pipeline. Optional hint path is compiled in with DECOMP_USEHINT_EN.
package decomp_pkg;

  localparam int unsigned Q         = 8380417;
  localparam int unsigned GAMMA2_88 = 95232;
  localparam int unsigned GAMMA2_32 = 261888;
  localparam int unsigned ALPHA_88  = 2 * GAMMA2_88;
  localparam int unsigned ALPHA_32  = 2 * GAMMA2_32;
  localparam int unsigned M_88      = 44;
  localparam int unsigned M_32      = 16;

  localparam logic [2:0] SEC_LVL_2 = 3'd2;

  localparam int unsigned COEF_W    = 23;
  localparam int unsigned LANE_R1_W = 6;
  localparam int unsigned LANE_R0_W = 19;

  typedef enum logic {
    MODE_32 = 1'b0,
    MODE_88 = 1'b1
  } mode_e;

  typedef struct packed {
    logic [LANE_R1_W-1:0]        r1;
    logic signed [LANE_R0_W-1:0] r0;
    logic                        err;
  } lane_res_t;

  // Number of high-part buckets for the given mode
  function automatic logic [LANE_R1_W-1:0] m_of(input mode_e mode);
    return (mode == MODE_88) ? LANE_R1_W'(M_88) : LANE_R1_W'(M_32);
  endfunction

endpackage

// File: rtl/decomp_lane.sv
// decomp_lane: per-coefficient S2 (quotient + raw centred remainder) and
// S3 (q-1 wrap, range-error mask, optional hint) datapath.
// Hint input exists only when DECOMP_USEHINT_EN is defined.
module decomp_lane
  import decomp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en2,
  input  logic                 en3,
  input  logic                 is_88,
  input  logic [COEF_W-1:0]    r,
`ifdef DECOMP_USEHINT_EN
  input  logic                 hint,
`endif
  output logic [LANE_R1_W-1:0] r1,
  output logic [LANE_R0_W-1:0] r0,
  output logic                 err
);

  logic [23:0] rr;
  assign rr = {1'b0, r};

  logic [LANE_R1_W-1:0] t88, t32;
  logic [23:0]          b88, b32;

  // Compare ladders: largest k with k*alpha <= r, for both modes
  always_comb begin
    t88 = '0;
    b88 = '0;
    t32 = '0;
    b32 = '0;
    for (int unsigned k = 1; k <= M_88; k++) begin
      if (rr >= 24'(k * ALPHA_88)) begin
        t88 = LANE_R1_W'(k);
        b88 = 24'(k * ALPHA_88);
      end
    end
    for (int unsigned k = 1; k <= M_32; k++) begin
      if (rr >= 24'(k * ALPHA_32)) begin
        t32 = LANE_R1_W'(k);
        b32 = 24'(k * ALPHA_32);
      end
    end
  end

  logic [23:0]                 alpha, gamma2, base, rem;
  logic [LANE_R1_W-1:0]        tq;
  logic [LANE_R1_W-1:0]        r1p_d;
  logic signed [LANE_R0_W-1:0] r0p_d;
  logic                        err_d;

  // Centre the remainder into (-gamma2, gamma2], bumping the quotient when folded
  always_comb begin
    alpha  = is_88 ? 24'(ALPHA_88)  : 24'(ALPHA_32);
    gamma2 = is_88 ? 24'(GAMMA2_88) : 24'(GAMMA2_32);
    tq     = is_88 ? t88 : t32;
    base   = is_88 ? b88 : b32;
    rem    = rr - base;
    err_d  = (rr >= 24'(Q));
    if (rem > gamma2) begin
      r1p_d = tq + LANE_R1_W'(1);
      r0p_d = LANE_R0_W'(rem - alpha);
    end else begin
      r1p_d = tq;
      r0p_d = LANE_R0_W'(rem);
    end
  end

  logic [LANE_R1_W-1:0]        r1p_q;
  logic signed [LANE_R0_W-1:0] r0p_q;
  logic                        err_q;
  mode_e                       mode_q;
  logic                        hint_q;

  // S2 register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1p_q  <= '0;
      r0p_q  <= '0;
      err_q  <= 1'b0;
      mode_q <= MODE_32;
      hint_q <= 1'b0;
    end else if (en2) begin
      r1p_q  <= r1p_d;
      r0p_q  <= r0p_d;
      err_q  <= err_d;
      mode_q <= is_88 ? MODE_88 : MODE_32;
`ifdef DECOMP_USEHINT_EN
      hint_q <= hint;
`else
      hint_q <= 1'b0;
`endif
    end
  end

  lane_res_t            res_d, res_q;
  logic [LANE_R1_W-1:0] m_cur;
  logic [LANE_R1_W-1:0] r1c;
  logic [LANE_R0_W-1:0] r0c;
  logic                 r0_pos;

  // S3 combinational: q-1 wrap, optional hint adjust, error mask
  always_comb begin
    m_cur = m_of(mode_q);
    if (r1p_q == m_cur) begin
      r1c = '0;
      r0c = r0p_q - LANE_R0_W'(1);
    end else begin
      r1c = r1p_q;
      r0c = r0p_q;
    end
    r0_pos = !r0c[LANE_R0_W-1] && (r0c != '0);
    if (hint_q) begin
      if (r0_pos) begin
        r1c = (r1c == m_cur - LANE_R1_W'(1)) ? '0 : r1c + LANE_R1_W'(1);
      end else begin
        r1c = (r1c == '0) ? m_cur - LANE_R1_W'(1) : r1c - LANE_R1_W'(1);
      end
    end
    res_d = '0;
    if (err_q) begin
      res_d.err = 1'b1;
    end else begin
      res_d.r1 = r1c;
      res_d.r0 = r0c;
    end
  end

  // S3 register stage (drives the outputs directly)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (en3) begin
      res_q <= res_d;
    end
  end

  assign r1  = res_q.r1;
  assign r0  = res_q.r0;
  assign err = res_q.err;

endmodule

// File: rtl/decomp_pipe.sv
// decomp_pipe: 3-stage, multi-lane Dilithium Decompose with ready/valid
// handshaking. Optional per-lane hint is enabled by DECOMP_USEHINT_EN.
module decomp_pipe
  import decomp_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DIN_W = 23,
  parameter int unsigned R1_W  = 6,
  parameter int unsigned R0_W  = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             sec_lvl,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*DIN_W-1:0] din,
`ifdef DECOMP_USEHINT_EN
  input  logic [LANES-1:0]       hint_in,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*R1_W-1:0]  r1_out,
  output logic [LANES*R0_W-1:0]  r0_out,
  output logic [LANES-1:0]       err_out
);

  logic v1, v2, v3;
  logic stall, en1, en2, en3, accept;

  // Stall drives in_ready; an empty stage keeps loading from upstream, and the
  // upstream stage moves at the same time, so a beat is never copied.
  always_comb begin
    stall    = v3 && !out_ready;
    en3      = !stall;
    en2      = !v2 || en3;
    en1      = !v1 || en2;
    in_ready = !stall;
    accept   = in_valid && in_ready;
  end

  logic [LANES*DIN_W-1:0] din_s1;
  mode_e                  mode_s1;
`ifdef DECOMP_USEHINT_EN
  logic [LANES-1:0]       hint_s1;
`endif

  // S1: register accepted beat and its mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      din_s1  <= '0;
      mode_s1 <= MODE_32;
`ifdef DECOMP_USEHINT_EN
      hint_s1 <= '0;
`endif
    end else if (en1) begin
      v1 <= accept;
      if (accept) begin
        din_s1  <= din;
        mode_s1 <= (sec_lvl == SEC_LVL_2) ? MODE_88 : MODE_32;
`ifdef DECOMP_USEHINT_EN
        hint_s1 <= hint_in;
`endif
      end
    end
  end

  // S2/S3 valid bits follow the data stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  assign out_valid = v3;

  logic [LANE_R1_W-1:0] lane_r1  [LANES];
  logic [LANE_R0_W-1:0] lane_r0  [LANES];
  logic                 lane_err [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    decomp_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en2   (en2),
      .en3   (en3),
      .is_88 (mode_s1 == MODE_88),
      .r     (din_s1[i*DIN_W +: DIN_W]),
`ifdef DECOMP_USEHINT_EN
      .hint  (hint_s1[i]),
`endif
      .r1    (lane_r1[i]),
      .r0    (lane_r0[i]),
      .err   (lane_err[i])
    );

    assign r1_out[i*R1_W +: R1_W] = R1_W'(lane_r1[i]);
    assign r0_out[i*R0_W +: R0_W] = R0_W'(lane_r0[i]);
    assign err_out[i]             = lane_err[i];
  end

endmodule
